// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes one WIDTH-bit word per load handshake and
// shifts it onto ser_out one bit per clock. Optional even-parity bit: define PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [CNT_W-1:0] bit_cnt, cnt_n;
`ifdef PARITY_EN
  logic             parity, parity_n;
`endif
  logic             accept;
  logic             head_n;
  logic             final_n;
  logic             out_n;

  // Next-state logic; the outputs below are decoded from the next state and then
  // registered, so ser_out never sees d_in combinationally.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    accept  = load_valid && load_ready;
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = bit_cnt;
`ifdef PARITY_EN
    parity_n = parity;
`endif

    case (state)
      SHIFT: begin
        shift_n = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
        cnt_n   = bit_cnt + CNT_W'(1);
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
          state_n = PARITY;
`else
          state_n = IDLE;
          cnt_n   = '0;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
`endif
      default: ;
    endcase

    // Acceptance is only possible in IDLE or the final-bit cycle, and overrides both.
    if (accept) begin
      state_n = SHIFT;
      shift_n = d_in;
      cnt_n   = '0;
`ifdef PARITY_EN
      parity_n = ^d_in;
`endif
    end

    head_n = MSB_FIRST ? shift_n[WIDTH-1] : shift_n[0];
`ifdef PARITY_EN
    final_n = (state_n == PARITY);
    out_n   = ((state_n == SHIFT) && head_n) || ((state_n == PARITY) && parity_n);
`else
    final_n = (state_n == SHIFT) && (cnt_n == LAST_BIT);
    out_n   = (state_n == SHIFT) && head_n;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
`ifdef PARITY_EN
      parity     <= 1'b0;
`endif
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state      <= state_n;
      shift_reg  <= shift_n;
      bit_cnt    <= cnt_n;
`ifdef PARITY_EN
      parity     <= parity_n;
`endif
      ser_out    <= out_n;
      ser_valid  <= (state_n != IDLE);
      frame_done <= final_n;
      load_ready <= (state_n == IDLE) || final_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer; runs an MSB-first and an LSB-first
// instance side by side on the same stimulus. Honours PARITY_EN for 9-bit frames.
module tb_piso_serializer;

`ifdef PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic       load_valid;
  logic       load_ready_m, ser_out_m, ser_valid_m, frame_done_m;
  logic       load_ready_l, ser_out_l, ser_valid_l, frame_done_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .d_in(d_in), .load_valid(load_valid),
    .load_ready(load_ready_m), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .frame_done(frame_done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .d_in(d_in), .load_valid(load_valid),
    .load_ready(load_ready_l), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .frame_done(frame_done_l)
  );

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ser_valid_m"}, ser_valid_m, 1'b0);
    check({tag, " ser_out_m"}, ser_out_m, 1'b0);
    check({tag, " frame_done_m"}, frame_done_m, 1'b0);
    check({tag, " load_ready_m"}, load_ready_m, 1'b1);
    check({tag, " ser_valid_l"}, ser_valid_l, 1'b0);
    check({tag, " load_ready_l"}, load_ready_l, 1'b1);
  endtask

  // Called in the first-bit cycle; returns in the final cycle without advancing.
  // At bit index stall_at it raises load_valid with word nxt.
  task automatic expect_frame(input string tag, input logic [7:0] w,
                              input int stall_at, input logic [7:0] nxt);
    for (int i = 0; i < FLEN; i++) begin
      logic last, bm, bl;
      string t;
      last = (i == FLEN - 1);
      bm   = (i < 8) ? w[7-i] : ^w;
      bl   = (i < 8) ? w[i] : ^w;
      t    = $sformatf("%s bit%0d", tag, i);
      check({t, " ser_valid_m"}, ser_valid_m, 1'b1);
      check({t, " ser_out_m"}, ser_out_m, bm);
      check({t, " frame_done_m"}, frame_done_m, last);
      check({t, " load_ready_m"}, load_ready_m, last);
      check({t, " ser_valid_l"}, ser_valid_l, 1'b1);
      check({t, " ser_out_l"}, ser_out_l, bl);
      check({t, " frame_done_l"}, frame_done_l, last);
      check({t, " load_ready_l"}, load_ready_l, last);
      if (i == stall_at) begin
        load_valid = 1'b1;
        d_in       = nxt;
      end
      if (!last) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    d_in       = 8'h00;

    // Reset state, while rst is held and just after release.
    #12;
    check("in_reset ser_valid_m", ser_valid_m, 1'b0);
    check("in_reset ser_out_m", ser_out_m, 1'b0);
    check("in_reset frame_done_m", frame_done_m, 1'b0);
    #3 rst = 1'b0;
    #1;
    check_idle("after_reset");
    tick();

    // Single word A5, one-cycle load pulse.
    d_in       = 8'hA5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    d_in       = 8'h00;
    expect_frame("a5", 8'hA5, -1, 8'h00);
    tick();
    check_idle("a5_end");

    // Word 01: LSB-first instance sends 1 then seven zeros.
    d_in       = 8'h01;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame("w01", 8'h01, -1, 8'h00);
    tick();
    check_idle("w01_end");

    // Back-to-back FF then 00 with load_valid held throughout.
    d_in       = 8'hFF;
    load_valid = 1'b1;
    tick();
    d_in       = 8'h00;
    expect_frame("b2b_ff", 8'hFF, -1, 8'h00);
    tick();
    expect_frame("b2b_00", 8'h00, -1, 8'h00);
    load_valid = 1'b0;
    tick();
    check_idle("b2b_end");

    // Stall: 3C requested during bit 3 of 5A, accepted only at the final cycle.
    d_in       = 8'h5A;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame("stall_5a", 8'h5A, 3, 8'h3C);
    tick();
    load_valid = 1'b0;
    expect_frame("stall_3c", 8'h3C, -1, 8'h00);
    tick();
    check_idle("stall_end");

    // Asynchronous reset during bit 4 of C3.
    d_in       = 8'hC3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort bit%0d ser_valid_m", i), ser_valid_m, 1'b1);
      check($sformatf("abort bit%0d ser_out_m", i), ser_out_m, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("abort bit4 ser_valid_m", ser_valid_m, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort ser_valid_m", ser_valid_m, 1'b0);
    check("abort ser_out_m", ser_out_m, 1'b0);
    check("abort frame_done_m", frame_done_m, 1'b0);
    check("abort ser_valid_l", ser_valid_l, 1'b0);
    tick();
    check("abort held frame_done_m", frame_done_m, 1'b0);
    #3 rst = 1'b0;
    #1;
    check_idle("abort_release");
    tick();
    check_idle("abort_idle");
    d_in       = 8'h81;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame("w81", 8'h81, -1, 8'h00);
    tick();
    check_idle("w81_end");

    // Parity-relevant words (odd and even popcount).
    d_in       = 8'h07;
    load_valid = 1'b1;
    tick();
    d_in       = 8'h03;
    expect_frame("w07", 8'h07, -1, 8'h00);
    tick();
    load_valid = 1'b0;
    expect_frame("w03", 8'h03, -1, 8'h00);
    tick();
    check_idle("par_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
